// File: rtl/bus_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register
// offsets, CTRL field positions, mode encodings and the counter FSM states.
package bus_timer_pkg;

  // Word offsets within the 16-byte register window
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int EN      = 0;
  localparam int MODE_LO = 1;
  localparam int MODE_HI = 2;
  localparam int IM      = 3;

  // MODE encodings; anything other than auto-reload behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  // Collapse the raw MODE field onto the two behaviours the timer implements
  function automatic logic [1:0] effective_mode(input logic [1:0] mode);
    return (mode == MODE_RELOAD) ? MODE_RELOAD : MODE_ONESHOT;
  endfunction

endpackage

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer responding on the CPU system bus.
// Holds CTRL/PRESET/COUNT, decodes its own 16-byte window, and raises irq
// when the count expires (masked by CTRL.IM).
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        irq
);

  logic        hit;
  logic [1:0]  offset;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        reload_mode;

  logic [3:0]  ctrl;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_flag;

  state_t      state;
  state_t      state_next;
  logic        count_load;
  logic        count_dec;
  logic        clear_en;
  logic        flag_set;
  logic        flag_clr_load;

  assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset      = addr[3:2];
  assign ctrl_wr     = we && hit && (offset == OFF_CTRL);
  assign preset_wr   = we && hit && (offset == OFF_PRESET);
  assign reload_mode = (effective_mode(ctrl[MODE_HI:MODE_LO]) == MODE_RELOAD);
  assign irq         = irq_flag & ctrl[IM];

  // Zero-latency read mux; misses and the reserved slot read as zero
  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (offset)
        OFF_CTRL:   rdata = {28'd0, ctrl};
        OFF_PRESET: rdata = preset_q;
        OFF_COUNT:  rdata = count_q;
        default:    rdata = 32'd0;
      endcase
    end
  end

  // Counter FSM next-state and the per-state actions on COUNT, CTRL.EN and irq_flag
  always_comb begin
    state_next    = state;
    count_load    = 1'b0;
    count_dec     = 1'b0;
    clear_en      = 1'b0;
    flag_set      = 1'b0;
    flag_clr_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (ctrl[EN]) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        count_load    = 1'b1;
        flag_clr_load = reload_mode;
        state_next    = S_CNT;
      end
      S_CNT: begin
        if (!ctrl[EN]) begin
          state_next = S_IDLE;
        end else if (count_q == 32'd0) begin
          flag_set   = 1'b1;
          state_next = S_INT;
        end else begin
          count_dec = 1'b1;
        end
      end
      S_INT: begin
        flag_set = 1'b1;
        if (reload_mode) begin
          state_next = S_LOAD;
        end else begin
          clear_en   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // CTRL: a bus write takes priority over the one-shot auto-clear of EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl <= 4'd0;
    end else if (ctrl_wr) begin
      ctrl <= wdata[3:0];
    end else if (clear_en) begin
      ctrl[EN] <= 1'b0;
    end
  end

  // PRESET only changes on a bus write; the FSM samples it when loading
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preset_q <= 32'd0;
    end else if (preset_wr) begin
      preset_q <= wdata;
    end
  end

  // COUNT is loaded or decremented only by the FSM; bus writes never touch it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 32'd0;
    end else if (count_load) begin
      count_q <= preset_q;
    end else if (count_dec) begin
      count_q <= count_q - 32'd1;
    end
  end

  // Interrupt flag: the hardware set beats any clear so no expiry is lost
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_flag <= 1'b0;
    end else if (flag_set) begin
      irq_flag <= 1'b1;
    end else if (ctrl_wr || flag_clr_load) begin
      irq_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed scenarios plus randomized
// timer runs, with expectations from a timeline-arithmetic reference model
// pushed into a scoreboard and checked by an independent monitor.
module tb_bus_timer;

  localparam logic [29:0] W_BASE   = 30'h0000_1FC0;
  localparam logic [29:0] W_CTRL   = W_BASE;
  localparam logic [29:0] W_PRESET = W_BASE + 30'd1;
  localparam logic [29:0] W_COUNT  = W_BASE + 30'd2;
  localparam logic [29:0] W_RSVD   = W_BASE + 30'd3;
  localparam logic [29:0] W_OUT    = W_BASE + 30'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        irq;

  typedef struct {
    string       name;
    bit          chk_rd;
    logic [31:0] rd;
    logic        irq_v;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  bus_timer #(.BASE_ADDR(32'h0000_7F00)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Single comparison point for every scoreboard entry
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: mid-cycle, pop whatever the stimulus side expects and compare
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk_rd) checkOutput({e.name, "_rdata"}, rdata, e.rd);
      checkOutput({e.name, "_irq"}, {31'd0, irq}, {31'd0, e.irq_v});
    end
  end

  // Drive one bus cycle just after the edge and queue the expected outputs for it
  task automatic applyStimulus(input logic rst_v, input logic [29:0] a, input logic [31:0] wd,
                               input logic w, input bit chk, input logic [31:0] exp_rd,
                               input logic exp_irq, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_v;
    addr  = a;
    wdata = wd;
    we    = w;
    e.name   = name;
    e.chk_rd = chk;
    e.rd     = exp_rd;
    e.irq_v  = exp_irq;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [29:0] a, input logic [31:0] e, input logic ei, input string n);
    applyStimulus(1'b1, a, $urandom, 1'b0, 1'b1, e, ei, n);
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] wd, input logic [31:0] e,
                    input logic ei, input string n);
    applyStimulus(1'b1, a, wd, 1'b1, 1'b1, e, ei, n);
  endtask

  // Reference timeline: k cycles after the enabling CTRL write (from reset),
  // COUNT holds PRESET two cycles later, expiry falls N+3 cycles after the
  // write, reload repeats every N+3 cycles with a 2-cycle irq pulse.
  // d >= 0 means CTRL was written to 0 at edge d (while counting).
  function automatic void model(input longint n, input logic [3:0] c, input int d, input int k,
                                output logic [31:0] cnt, output logic [3:0] ctl, output logic ie);
    longint p;
    longint j;
    longint kk;
    bit     rl;
    bit     flag;
    p  = n + 3;
    kk = longint'(k);
    rl = (c[2:1] == 2'b01);
    if (d >= 0 && k >= d) begin
      cnt = 32'(n - longint'(d - 2));
      ctl = 4'd0;
      ie  = 1'b0;
    end else begin
      if (k < 2) begin
        cnt = 32'd0;
      end else begin
        j = rl ? (kk - 2) % p : (kk - 2);
        if (j <= n) cnt = 32'(n - j);
        else        cnt = 32'd0;
      end
      flag = (kk >= n + 3) && (!rl || ((kk - n - 3) % p) < 2);
      ie   = flag && c[3];
      ctl  = (!rl && kk >= n + 4) ? {c[3:1], 1'b0} : c;
    end
  endfunction

  // Reset, program PRESET and CTRL, then watch len cycles of reads
  task automatic runScenario(input logic [31:0] n, input logic [3:0] c, input int d, input int len,
                             input int sel_fixed, input string tag);
    logic [31:0] wd;
    logic [31:0] cnt;
    logic [3:0]  ctl;
    logic        ie;
    int          sel;
    string       nm;
    applyStimulus(1'b0, W_CTRL, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0, {tag, "_rst"});
    wr(W_PRESET, n, 32'd0, 1'b0, {tag, "_pwr"});
    wd = $urandom;
    wd[3:0] = c;
    wr(W_CTRL, wd, 32'd0, 1'b0, {tag, "_cwr"});
    for (int k = 0; k < len; k++) begin
      model(longint'(n), c, d, k, cnt, ctl, ie);
      nm = $sformatf("%s_k%0d", tag, k);
      if (k == d - 1) begin
        wr(W_CTRL, 32'd0, {28'd0, ctl}, ie, {nm, "_dis"});
      end else begin
        sel = (sel_fixed >= 0) ? sel_fixed : int'($urandom_range(0, 4));
        case (sel)
          0:       rd(W_CTRL, {28'd0, ctl}, ie, nm);
          1:       rd(W_PRESET, n, ie, nm);
          2:       rd(W_COUNT, cnt, ie, nm);
          3:       rd(W_RSVD, 32'd0, ie, nm);
          default: rd(W_OUT + 30'($urandom_range(0, 3)), 32'd0, ie, nm);
        endcase
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: bench did not complete within the time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] pm_cnt [9] = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1};
    logic        pm_irq [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int          ni;
    int          di;
    logic [3:0]  ci;

    reset = 1'b0;
    addr  = 30'd0;
    wdata = 32'd0;
    we    = 1'b0;
    repeat (2) @(posedge clk);

    // One-shot: irq from 6 cycles after the write, EN self-clears, CTRL write drops irq
    runScenario(32'd3, 4'b1001, -1, 8, 0, "oneshot");
    wr(W_CTRL, 32'd0, 32'd8, 1'b1, "os_clr");
    rd(W_CTRL, 32'd0, 1'b0, "os_cleared");

    // Auto-reload: period 5, COUNT sequence 2,1,0
    runScenario(32'd2, 4'b1011, -1, 17, 2, "reload");

    // Masked expiry, then unmasking via CTRL write clears the pending flag
    runScenario(32'd1, 4'b0001, -1, 10, -1, "mask");
    wr(W_CTRL, 32'd8, 32'd0, 1'b0, "mask_wr");
    rd(W_CTRL, 32'd8, 1'b0, "mask_im");

    // Disable mid-count freezes at 8; COUNT writes ignored; re-enable reloads
    runScenario(32'd10, 4'b0001, 4, 10, 2, "dis");
    wr(W_COUNT, 32'd7, 32'd8, 1'b0, "dis_cntwr");
    rd(W_COUNT, 32'd8, 1'b0, "dis_frozen");
    wr(W_CTRL, 32'd1, 32'd0, 1'b0, "dis_reen");
    rd(W_COUNT, 32'd8, 1'b0, "reen_k0");
    rd(W_COUNT, 32'd8, 1'b0, "reen_k1");
    rd(W_COUNT, 32'd10, 1'b0, "reen_k2");
    rd(W_COUNT, 32'd9, 1'b0, "reen_k3");

    // Largest PRESET decrements plainly
    runScenario(32'hFFFF_FFFF, 4'b1001, -1, 6, 2, "big");

    // CTRL write on the edge entering INT: irq still asserted
    runScenario(32'd0, 4'b1001, -1, 2, 0, "coll");
    wr(W_CTRL, 32'd8, 32'd9, 1'b0, "coll_wr");
    rd(W_CTRL, 32'd8, 1'b1, "coll_irq");
    rd(W_CTRL, 32'd8, 1'b1, "coll_hold");

    // Writes just outside the window change nothing and read back 0
    wr(W_OUT, 32'h0000_00F7, 32'd0, 1'b1, "oow_wr0");
    wr(W_OUT + 30'd1, 32'h0000_1234, 32'd0, 1'b1, "oow_wr1");
    rd(W_CTRL, 32'd8, 1'b1, "oow_ctrl");
    rd(W_PRESET, 32'd0, 1'b1, "oow_preset");

    // PRESET rewritten while counting only affects the next reload
    runScenario(32'd3, 4'b1011, -1, 3, 2, "pmid");
    wr(W_PRESET, 32'd1, 32'd3, 1'b0, "pmid_wr");
    for (int i = 0; i < 9; i++) begin
      rd(W_COUNT, pm_cnt[i], pm_irq[i], $sformatf("pmid_k%0d", i + 4));
    end

    // Reset while irq is high and while counting clears everything at once
    runScenario(32'd0, 4'b1001, -1, 5, 2, "rstirq");
    applyStimulus(1'b0, W_COUNT, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0, "rst_irq");
    runScenario(32'd5, 4'b1001, -1, 3, 2, "rstcnt");
    applyStimulus(1'b0, W_COUNT, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0, "rst_count");
    applyStimulus(1'b1, W_CTRL, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0, "rst_hold");
    rd(W_CTRL, 32'd0, 1'b0, "rst_ctrl");

    // Randomized runs: random PRESET, MODE, IM, and sometimes a mid-count disable
    for (int i = 0; i < 12; i++) begin
      ni = int'($urandom_range(0, 6));
      ci = {3'($urandom_range(0, 7)), 1'b1};
      di = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, ni + 2)) : -1;
      runScenario(32'(ni), ci, di, 2 * (ni + 3) + 6, -1, $sformatf("rnd%0d", i));
    end

    @(posedge clk);
    #1;
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
